multi_operand_accumulator: RTL and testbench
============================================

// Module: multi_operand_accumulator
// PURPOSE
//  Sequencer upstream of the 8-bit conditional-sum adder: consumes a stream of 8-bit operands
//  and accumulates them into a 16-bit total.
//  Each operand costs two adder passes (low byte, then high byte + carry), so the single 8-bit
//  adder is reused.
//  Result is offered on a valid/ready output with a sticky overflow flag.
// PARAMETERS
//  DATA_W   8   operand/adder width; fixed at 8 to match the conditional-sum adder
//  ACC_W    16  accumulator width (= 2*DATA_W)
//  CNT_W    5   width of op_count; up to 31 operands per run
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      begin a run; sampled only in IDLE
//  op_count   in   CNT_W  number of operands in the run; sampled with start
//  acc_init   in   ACC_W  accumulator start value; sampled with start
//  in_valid   in   1      operand available
//  in_data    in   DATA_W operand
//  in_ready   out  1      block accepts operand this cycle
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  acc_out    out  ACC_W  accumulator value (meaningful when out_valid=1)
//  ovf        out  1      sticky: carry out of bit 15 at any point in the run
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=IDLE; acc=0, cnt=0, opnd=0, carry_r=0, ovf=0.
//    Outputs in_ready=0, out_valid=0, busy=0, acc_out=0.
//  - Reset mid-run aborts the run immediately. The pending operand and result are discarded.
//  - FSM: IDLE, LOAD, ADD_LO, ADD_HI, DONE (registered state; outputs decoded from state).
//  - IDLE: start=1 and op_count!=0 -> acc<=acc_init, ovf<=0, cnt<=op_count, go LOAD.
//    start=1 and op_count==0 -> acc<=acc_init, ovf<=0, go DONE.
//  - LOAD: in_ready=1. On in_valid&in_ready, opnd<=in_data and go ADD_LO. Otherwise wait.
//  - ADD_LO: adder A=acc[7:0], B=opnd, Cin=0. At the edge: acc[7:0]<=S, carry_r<=Cout.
//    Go ADD_HI.
//  - ADD_HI: adder A=acc[15:8], B=8'h00, Cin=carry_r. At the edge: acc[15:8]<=S,
//    ovf<=ovf|Cout, cnt<=cnt-1. Then cnt==1 -> DONE, else -> LOAD.
//  - DONE: out_valid=1; acc_out/ovf held stable. out_ready=1 -> IDLE (out_valid drops next cycle).
//  - Arithmetic is modulo 2^16; wrap-around sets ovf and the run continues.
//  - start outside IDLE is ignored. in_valid outside LOAD is ignored; in_data is not consumed.
//  - Latency: 3 cycles per operand when in_valid stays high.
//    out_valid rises the cycle after the final ADD_HI.
//    op_count==0 gives out_valid the cycle after start.
//  - Simultaneous out_ready and start in DONE: start is ignored (not IDLE).
//  - in_ready and out_valid are never both high.
// STRUCTURE
//  - Shared package/header: FSM state localparams (IDLE=0, LOAD=1, ADD_LO=2, ADD_HI=3, DONE=4).
//    Also DATA_W/ACC_W constants.
//  - One sub-module: the existing 8-bit conditional-sum adder, instantiated once.
//    Operands are muxed by state; everything else stays in this module.
// TESTING
//  1. acc_init=0, op_count=3, data 8'h10, 8'h20, 8'h30 back-to-back
//     -> acc_out=16'h0060, ovf=0, out_valid 9 cycles after the first accept.
//  2. acc_init=0, op_count=2, data 8'hFF, 8'h01 -> acc_out=16'h0100, ovf=0 (low-to-high carry).
//  3. acc_init=16'hFFF0, op_count=1, data 8'h20 -> acc_out=16'h0010, ovf=1 (wrap-around).
//  4. op_count=2; in_valid gaps of 4 cycles; out_ready held low 5 cycles; start pulsed while busy
//     -> in_ready waits; out_valid and acc_out stable until out_ready; extra start has no effect.
//  5. op_count=0, acc_init=16'h1234 -> out_valid=1 next cycle with acc_out=16'h1234, ovf=0.
//  6. rst=1 after the 2nd of 4 operands -> next cycle busy=0, in_ready=0, out_valid=0, acc_out=0.
//     A fresh run (8'h05 x2) then gives 16'h000A.

Source files
------------

// File: rtl/multi_operand_accumulator_pkg.sv
// Shared constants and FSM encoding for the multi-operand accumulator and its adder.
package multi_operand_accumulator_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 2 * DATA_W;
  localparam int CNT_W  = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ADD_LO = 3'd2,
    ADD_HI = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/multi_operand_accumulator_csa.sv
// 8-bit conditional-sum adder: every block computes both carry-in outcomes, and each level
// doubles the block size by letting the low half's carry choose the high half's result.
module multi_operand_accumulator_csa
  import multi_operand_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  // s0_*/c0_* assume a carry-in of 0 into the block, s1_*/c1_* assume 1.
  logic [7:0] s0_l0, s1_l0, c0_l0, c1_l0;
  logic [7:0] s0_l1, s1_l1;
  logic [3:0] c0_l1, c1_l1;
  logic [7:0] s0_l2, s1_l2;
  logic [1:0] c0_l2, c1_l2;
  logic [7:0] s0_l3, s1_l3;
  logic       c0_l3, c1_l3;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      assign s0_l0[gi] = a[gi] ^ b[gi];
      assign s1_l0[gi] = ~(a[gi] ^ b[gi]);
      assign c0_l0[gi] = a[gi] & b[gi];
      assign c1_l0[gi] = a[gi] | b[gi];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_pair
      assign s0_l1[2*gi]   = s0_l0[2*gi];
      assign s1_l1[2*gi]   = s1_l0[2*gi];
      assign s0_l1[2*gi+1] = c0_l0[2*gi] ? s1_l0[2*gi+1] : s0_l0[2*gi+1];
      assign s1_l1[2*gi+1] = c1_l0[2*gi] ? s1_l0[2*gi+1] : s0_l0[2*gi+1];
      assign c0_l1[gi]     = c0_l0[2*gi] ? c1_l0[2*gi+1] : c0_l0[2*gi+1];
      assign c1_l1[gi]     = c1_l0[2*gi] ? c1_l0[2*gi+1] : c0_l0[2*gi+1];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_nibble
      assign s0_l2[4*gi+1:4*gi]   = s0_l1[4*gi+1:4*gi];
      assign s1_l2[4*gi+1:4*gi]   = s1_l1[4*gi+1:4*gi];
      assign s0_l2[4*gi+3:4*gi+2] = c0_l1[2*gi] ? s1_l1[4*gi+3:4*gi+2] : s0_l1[4*gi+3:4*gi+2];
      assign s1_l2[4*gi+3:4*gi+2] = c1_l1[2*gi] ? s1_l1[4*gi+3:4*gi+2] : s0_l1[4*gi+3:4*gi+2];
      assign c0_l2[gi]            = c0_l1[2*gi] ? c1_l1[2*gi+1] : c0_l1[2*gi+1];
      assign c1_l2[gi]            = c1_l1[2*gi] ? c1_l1[2*gi+1] : c0_l1[2*gi+1];
    end
  endgenerate

  assign s0_l3[3:0] = s0_l2[3:0];
  assign s1_l3[3:0] = s1_l2[3:0];
  assign s0_l3[7:4] = c0_l2[0] ? s1_l2[7:4] : s0_l2[7:4];
  assign s1_l3[7:4] = c1_l2[0] ? s1_l2[7:4] : s0_l2[7:4];
  assign c0_l3      = c0_l2[0] ? c1_l2[1] : c0_l2[1];
  assign c1_l3      = c1_l2[0] ? c1_l2[1] : c0_l2[1];

  // The real carry-in picks the final pair last, so it sits on the shortest path.
  assign sum  = cin ? s1_l3 : s0_l3;
  assign cout = cin ? c1_l3 : c0_l3;

endmodule

// File: rtl/multi_operand_accumulator.sv
// Streams 8-bit operands into a 16-bit total using one 8-bit adder twice per operand
// (low byte, then high byte plus carry); the result is offered on a valid/ready port.
module multi_operand_accumulator
  import multi_operand_accumulator_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] op_count,
  input  logic [ACC_W-1:0] acc_init,
  input  logic             in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             busy
);

  state_t            state_reg, state_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] opnd_reg, opnd_next;
  logic              carry_reg, carry_next;
  logic              ovf_reg, ovf_next;

  logic [DATA_W-1:0] add_a, add_b, add_sum;
  logic              add_cin, add_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      opnd_reg  <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      opnd_reg  <= opnd_next;
      carry_reg <= carry_next;
      ovf_reg   <= ovf_next;
    end
  end

  // High pass adds only the saved carry, so B is zero there.
  always_comb begin
    add_a   = acc_reg[DATA_W-1:0];
    add_b   = opnd_reg;
    add_cin = 1'b0;
    if (state_reg == ADD_HI) begin
      add_a   = acc_reg[ACC_W-1:DATA_W];
      add_b   = '0;
      add_cin = carry_reg;
    end
  end

  multi_operand_accumulator_csa u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    opnd_next  = opnd_reg;
    carry_next = carry_reg;
    ovf_next   = ovf_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;

    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          acc_next = acc_init;
          ovf_next = 1'b0;
          if (op_count != '0) begin
            cnt_next   = op_count;
            state_next = LOAD;
          end else begin
            state_next = DONE;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opnd_next  = in_data;
          state_next = ADD_LO;
        end
      end
      ADD_LO: begin
        acc_next[DATA_W-1:0] = add_sum;
        carry_next           = add_cout;
        state_next           = ADD_HI;
      end
      ADD_HI: begin
        acc_next[ACC_W-1:DATA_W] = add_sum;
        ovf_next                 = ovf_reg | add_cout;
        cnt_next                 = cnt_reg - CNT_W'(1);
        state_next               = (cnt_reg == CNT_W'(1)) ? DONE : LOAD;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign acc_out = acc_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Directed bench for multi_operand_accumulator: a run-level arithmetic model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_multi_operand_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op_count = '0;
  logic [15:0] acc_init = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] acc_out;
  logic        ovf;
  logic        busy;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  // Model: 0 = idle, 1 = taking operands, 2 = all operands taken / result pending or offered.
  int m_phase = 0;
  int m_left = 0;
  int m_sum = 0;
  bit m_fresh = 1'b1;

  multi_operand_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_count  (op_count),
    .acc_init  (acc_init),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_sum   = 0;
      m_fresh = 1'b1;
    end else begin
      chk("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
      chk("busy", 32'(busy), 32'(m_phase != 0));
      if (m_phase != 2) chk("out_valid_early", 32'(out_valid), 32'd0);
      if (m_phase != 1) chk("in_ready_unexpected", 32'(in_ready), 32'd0);
      if (out_valid) begin
        chk("model_acc", 32'(acc_out), 32'(m_sum & 32'hFFFF));
        chk("model_ovf", 32'(ovf), 32'(m_sum > 32'hFFFF));
      end
      if (m_fresh && m_phase == 0) begin
        chk("reset_acc", 32'(acc_out), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
      end
      case (m_phase)
        0: if (start) begin
          m_sum   = int'(acc_init);
          m_left  = int'(op_count);
          m_fresh = 1'b0;
          m_phase = (op_count == 5'd0) ? 2 : 1;
        end
        1: if (in_valid && in_ready) begin
          m_sum  = m_sum + int'(in_data);
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_valid && out_ready) m_phase = 0;
      endcase
    end
  end

  task automatic do_start(input logic [15:0] init, input logic [4:0] cnt);
    @(posedge clk); #1;
    start = 1'b1; acc_init = init; op_count = cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; waited = k; last_acc_cyc = cyc; break; end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("operand %02h accepted at cycle %0d after %0d wait cycles", d, last_acc_cyc, waited);
  endtask

  task automatic wait_out(output int at);
    bit got;
    got = 1'b0;
    at = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; at = cyc; break; end
    end
    if (!got) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_out(input bit with_start);
    @(posedge clk); #1;
    out_ready = 1'b1; start = with_start; op_count = 5'd1; acc_init = 16'hAAAA;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("idle_after_take", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w, t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acc_out", 32'(acc_out), 32'd0);

    // 1: back-to-back operands and latency
    do_start(16'h0000, 5'd3);
    send(8'h10, 0, w);
    t = last_acc_cyc;
    send(8'h20, 0, w);
    send(8'h30, 0, w);
    wait_out(w);
    chk("t1_latency", 32'(w - t), 32'd9);
    chk("t1_acc", 32'(acc_out), 32'h0060);
    chk("t1_ovf", 32'(ovf), 32'd0);
    $display("run1 acc_out=%04h ovf=%0d latency=%0d", acc_out, ovf, w - t);
    take_out(1'b0);

    // 2: carry from low byte into high byte
    do_start(16'h0000, 5'd2);
    send(8'hFF, 0, w);
    send(8'h01, 0, w);
    wait_out(w);
    chk("t2_acc", 32'(acc_out), 32'h0100);
    chk("t2_ovf", 32'(ovf), 32'd0);
    $display("run2 acc_out=%04h ovf=%0d", acc_out, ovf);
    take_out(1'b0);

    // 3: wrap-around past 16 bits
    do_start(16'hFFF0, 5'd1);
    send(8'h20, 0, w);
    wait_out(w);
    chk("t3_acc", 32'(acc_out), 32'h0010);
    chk("t3_ovf", 32'(ovf), 32'd1);
    $display("run3 acc_out=%04h ovf=%0d", acc_out, ovf);
    take_out(1'b0);

    // 4: input gaps, ignored start while busy, stalled consumer, start alongside out_ready
    do_start(16'h0100, 5'd2);
    @(posedge clk); #1;
    start = 1'b1; op_count = 5'd0; acc_init = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    send(8'h33, 4, w);
    chk("t4_ready_waiting1", 32'(w), 32'd0);
    send(8'h44, 4, w);
    chk("t4_ready_waiting2", 32'(w), 32'd0);
    wait_out(w);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_acc", 32'(acc_out), 32'h0177);
      chk("t4_hold_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
    end
    $display("run4 acc_out=%04h ovf=%0d held 5 cycles", acc_out, ovf);
    take_out(1'b1);

    // 5: empty run
    do_start(16'h1234, 5'd0);
    @(negedge clk);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_acc", 32'(acc_out), 32'h1234);
    chk("t5_ovf", 32'(ovf), 32'd0);
    $display("run5 acc_out=%04h ovf=%0d", acc_out, ovf);
    take_out(1'b0);

    // 6: reset mid-run, then a fresh run
    do_start(16'h0000, 5'd4);
    send(8'h11, 0, w);
    send(8'h22, 0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_acc", 32'(acc_out), 32'd0);
    $display("run6 aborted by reset, acc_out=%04h", acc_out);
    do_start(16'h0000, 5'd2);
    send(8'h05, 0, w);
    send(8'h05, 0, w);
    wait_out(w);
    chk("t6_fresh_acc", 32'(acc_out), 32'h000A);
    chk("t6_fresh_ovf", 32'(ovf), 32'd0);
    $display("run7 acc_out=%04h ovf=%0d", acc_out, ovf);
    take_out(1'b0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
